// File: rtl/sccb_init_pkg.sv
// Shared types and constants for the SCCB camera init sequencer.
package sccb_init_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    WRITE,
    WAIT_W,
    READ,
    WAIT_R,
    DELAY,
    NEXT,
    FINISH,
    ABORT
  } state_t;

  // Table opcodes carried in the sub_addr field
  localparam logic [7:0] OP_DELAY = 8'hF0;
  localparam logic [7:0] OP_END   = 8'hFF;

  // Register that is never read back (its write resets the sensor)
  localparam logic [7:0] REG_NO_VERIFY = 8'h12;

  typedef struct packed {
    logic [7:0] sub_addr;
    logic [7:0] value;
  } tbl_entry_t;

  // Cycle count for a delay entry; a 0 ms entry still waits 1 ms
  function automatic logic [31:0] delay_cycles(input logic [7:0] ms,
                                               input int unsigned cyc_per_ms);
    logic [31:0] n;
    n = (ms == 8'd0) ? 32'd1 : {24'd0, ms};
    return n * cyc_per_ms;
  endfunction

endpackage

// File: rtl/init_delay_timer.sv
// Millisecond delay timer: load with a ms count, pulses expired on the
// last cycle of the delay so the sequencer spends exactly ms*CYC_PER_MS
// cycles waiting.
module init_delay_timer
  import sccb_init_pkg::*;
#(
  parameter int unsigned CYC_PER_MS = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] ms,
  output logic       expired
);

  logic [31:0] remaining;
  logic        running;

  // Load the full cycle count, then count down while running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      running   <= 1'b0;
    end else if (load) begin
      remaining <= delay_cycles(ms, CYC_PER_MS);
      running   <= 1'b1;
    end else if (running) begin
      remaining <= remaining - 32'd1;
      if (remaining == 32'd1) running <= 1'b0;
    end
  end

  // Expiry coincides with the final counted cycle
  always_comb begin
    expired = running && (remaining == 32'd1);
  end

endmodule

// File: rtl/sccb_init_seq.sv
// Walks an external init table for each camera in turn, issuing SCCB
// register writes (optionally read back and compared), ms delays and
// retries, and reports completion or the failing camera/entry.
module sccb_init_seq
  import sccb_init_pkg::*;
#(
  parameter int unsigned NUM_CAM    = 2,
  parameter int unsigned TBL_DEPTH  = 64,
  parameter logic [7:0]  CHIP_ADDR  = 8'h42,
  parameter int unsigned CYC_PER_MS = 50000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        verify_en,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_cam,
  output logic [7:0]  err_idx,
  output logic [1:0]  cam_sel,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        m_start,
  output logic        m_rd,
  output logic [7:0]  m_addr,
  output logic [7:0]  m_subaddr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_done,
  input  logic        m_nack
);

  localparam logic [1:0] LAST_CAM = 2'(NUM_CAM - 1);
  localparam logic [7:0] LAST_IDX = 8'(TBL_DEPTH - 1);
  localparam logic [7:0] MAX_R    = 8'(MAX_RETRY);
  localparam logic [7:0] WR_ADDR  = CHIP_ADDR & 8'hFE;
  localparam logic [7:0] RD_ADDR  = CHIP_ADDR | 8'h01;

  state_t     state, next;
  tbl_entry_t fetched, entry;
  logic [7:0] retry;
  logic       verify_q;
  logic       start_go, retry_go, advance_go, abort_go, cam_go;
  logic       timer_load, timer_expired;

  assign fetched = tbl_data;

  init_delay_timer #(.CYC_PER_MS(CYC_PER_MS)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .ms      (fetched.value),
    .expired (timer_expired)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Next state; failures and advances are resolved after the case so
  // every wait state shares the same retry/advance rules
  always_comb begin
    logic fail;
    next       = state;
    fail       = 1'b0;
    start_go   = 1'b0;
    retry_go   = 1'b0;
    advance_go = 1'b0;
    abort_go   = 1'b0;
    cam_go     = 1'b0;
    timer_load = 1'b0;
    unique case (state)
      IDLE, FINISH, ABORT: begin
        if (start) begin
          next     = FETCH;
          start_go = 1'b1;
        end
      end
      FETCH: next = DECODE;
      DECODE: begin
        if (fetched.sub_addr == OP_END) begin
          next = NEXT;
        end else if (fetched.sub_addr == OP_DELAY) begin
          next       = DELAY;
          timer_load = 1'b1;
        end else begin
          next = WRITE;
        end
      end
      WRITE: next = WAIT_W;
      WAIT_W: begin
        if (m_done) begin
          if (m_nack) fail = 1'b1;
          else if (verify_q && entry.sub_addr != REG_NO_VERIFY) next = READ;
          else advance_go = 1'b1;
        end
      end
      READ: next = WAIT_R;
      WAIT_R: begin
        if (m_done) begin
          if (m_nack || m_rdata != entry.value) fail = 1'b1;
          else advance_go = 1'b1;
        end
      end
      DELAY: begin
        if (timer_expired) advance_go = 1'b1;
      end
      NEXT: begin
        if (cam_sel == LAST_CAM) begin
          next = FINISH;
        end else begin
          next   = FETCH;
          cam_go = 1'b1;
        end
      end
      default: next = IDLE;
    endcase
    if (fail) begin
      if (retry < MAX_R) begin
        retry_go = 1'b1;
        next     = WRITE;
      end else begin
        abort_go = 1'b1;
        next     = ABORT;
      end
    end
    if (advance_go) next = (tbl_addr == LAST_IDX) ? NEXT : FETCH;
  end

  // Table position, retry count, latched entry and abort location
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cam_sel  <= '0;
      tbl_addr <= '0;
      retry    <= '0;
      verify_q <= 1'b0;
      entry    <= '0;
      err_cam  <= '0;
      err_idx  <= '0;
    end else begin
      if (state == DECODE) entry <= fetched;
      if (start_go) begin
        cam_sel  <= '0;
        tbl_addr <= '0;
        retry    <= '0;
        verify_q <= verify_en;
        err_cam  <= '0;
        err_idx  <= '0;
      end
      if (retry_go) retry <= retry + 8'd1;
      if (abort_go) begin
        err_cam <= cam_sel;
        err_idx <= tbl_addr;
      end
      if (advance_go) begin
        retry <= '0;
        if (tbl_addr != LAST_IDX) tbl_addr <= tbl_addr + 8'd1;
      end
      if (cam_go) begin
        cam_sel  <= cam_sel + 2'd1;
        tbl_addr <= '0;
      end
    end
  end

  // Outputs decoded from state; idle states drive all bus fields to 0
  always_comb begin
    busy      = !(state == IDLE || state == FINISH || state == ABORT);
    done      = (state == FINISH);
    error     = (state == ABORT);
    m_start   = (state == WRITE) || (state == READ);
    m_rd      = (state == READ) || (state == WAIT_R);
    m_addr    = '0;
    m_subaddr = '0;
    m_wdata   = '0;
    if (state == WRITE || state == WAIT_W) begin
      m_addr    = WR_ADDR;
      m_subaddr = entry.sub_addr;
      m_wdata   = entry.value;
    end else if (state == READ || state == WAIT_R) begin
      m_addr    = RD_ADDR;
      m_subaddr = entry.sub_addr;
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench for sccb_init_seq with a behavioural SCCB slave and a
// synchronous init-table ROM.
module tb_sccb_init_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        verify_en = 1'b0;
  logic        busy, done, error;
  logic [1:0]  err_cam, cam_sel;
  logic [7:0]  err_idx, tbl_addr;
  logic [15:0] tbl_data;
  logic        m_start, m_rd;
  logic [7:0]  m_addr, m_subaddr, m_wdata, m_rdata;
  logic        m_done, m_nack;

  always #5 clk = ~clk;

  sccb_init_seq #(
    .NUM_CAM    (2),
    .TBL_DEPTH  (4),
    .CHIP_ADDR  (8'h42),
    .CYC_PER_MS (10),
    .MAX_RETRY  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .verify_en (verify_en),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_cam   (err_cam),
    .err_idx   (err_idx),
    .cam_sel   (cam_sel),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .m_start   (m_start),
    .m_rd      (m_rd),
    .m_addr    (m_addr),
    .m_subaddr (m_subaddr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_done    (m_done),
    .m_nack    (m_nack)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned s_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Init table ROM, one cycle latency
  logic [15:0] rom [2][4];
  always @(posedge clk) tbl_data <= rom[cam_sel[0]][tbl_addr[1:0]];

  // SCCB slave model and transaction log
  logic [7:0]  mem [2][256];
  int unsigned n_ms = 0, n_wr = 0, n_rd = 0;
  int unsigned corrupt_at = 32'hFFFF_FFFF;
  logic        nack_en = 1'b0;
  logic [1:0]  nack_cam = 2'd0;
  logic [7:0]  nack_sub = 8'd0;
  int unsigned ms_cyc [128];
  logic        ms_rdv [128];
  logic [7:0]  ms_addr [128];
  logic [7:0]  ms_sub [128];
  logic [7:0]  ms_dat [128];
  logic [1:0]  ms_cam [128];
  logic [7:0]  ms_tbl [128];
  int unsigned pend = 0;
  logic        p_nack = 1'b0;
  logic [7:0]  p_rdata = 8'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= 0;
      m_done  <= 1'b0;
      m_nack  <= 1'b0;
      m_rdata <= 8'd0;
    end else begin
      m_done <= 1'b0;
      m_nack <= 1'b0;
      if (pend == 1) begin
        m_done  <= 1'b1;
        m_nack  <= p_nack;
        m_rdata <= p_rdata;
      end
      if (pend != 0) pend <= pend - 1;
      if (m_start) begin
        if (n_ms < 128) begin
          ms_cyc[n_ms]  <= cyc;
          ms_rdv[n_ms]  <= m_rd;
          ms_addr[n_ms] <= m_addr;
          ms_sub[n_ms]  <= m_subaddr;
          ms_dat[n_ms]  <= m_wdata;
          ms_cam[n_ms]  <= cam_sel;
          ms_tbl[n_ms]  <= tbl_addr;
        end
        n_ms   <= n_ms + 1;
        pend   <= 3;
        p_nack <= nack_en && (cam_sel == nack_cam) && (m_subaddr == nack_sub);
        if (m_rd) begin
          p_rdata <= (n_rd == corrupt_at) ? (mem[cam_sel[0]][m_subaddr] ^ 8'h01)
                                          : mem[cam_sel[0]][m_subaddr];
          n_rd <= n_rd + 1;
        end else begin
          mem[cam_sel[0]][m_subaddr] <= m_wdata;
          n_wr <= n_wr + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tbl(input int c, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
    rom[c][0] = e0;
    rom[c][1] = e1;
    rom[c][2] = e2;
    rom[c][3] = e3;
  endtask

  task automatic pulse_start(input logic ven);
    @(negedge clk);
    start     = 1'b1;
    verify_en = ven;
    s_cyc     = cyc;
    @(negedge clk);
    start     = 1'b0;
    verify_en = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int unsigned k = 0;
    while ((busy || !(done || error)) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 32'(k >= 2000), 32'd0);
  endtask

  int unsigned b, w0, r0, cnt;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_done",    32'(done),     32'd0);
    chk("rst_error",   32'(error),    32'd0);
    chk("rst_mstart",  32'(m_start),  32'd0);
    chk("rst_cam",     32'(cam_sel),  32'd0);
    chk("rst_tbl",     32'(tbl_addr), 32'd0);
    chk("rst_errcam",  32'(err_cam),  32'd0);
    chk("rst_erridx",  32'(err_idx),  32'd0);
    chk("rst_maddr",   32'(m_addr),   32'd0);
    reset = 1'b0;

    // Two cameras, short table, all ACK; a start while busy is ignored
    set_tbl(0, 16'h1280, 16'h1100, 16'hFF00, 16'h0000);
    set_tbl(1, 16'h1280, 16'h1100, 16'hFF00, 16'h0000);
    b = n_ms;
    pulse_start(1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    cnt = 0;
    while (n_ms == b && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("t1_first_timeout", 32'(cnt >= 100), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("t1");
    chk("t1_nxact", n_ms - b, 32'd4);
    chk("t1_done",  32'(done),  32'd1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_cam0",  32'(ms_cam[b]),   32'd0);
    chk("t1_cam1",  32'(ms_cam[b+1]), 32'd0);
    chk("t1_cam2",  32'(ms_cam[b+2]), 32'd1);
    chk("t1_cam3",  32'(ms_cam[b+3]), 32'd1);
    chk("t1_addr",  32'(ms_addr[b]),  32'h42);
    chk("t1_rd",    32'(ms_rdv[b]),   32'd0);
    chk("t1_sub0",  32'(ms_sub[b]),   32'h12);
    chk("t1_dat0",  32'(ms_dat[b]),   32'h80);
    chk("t1_sub1",  32'(ms_sub[b+1]), 32'h11);
    chk("t1_dat1",  32'(ms_dat[b+1]), 32'h00);
    chk("t1_lat",   ms_cyc[b] - s_cyc, 32'd3);

    // 2 ms delay at 10 cycles/ms: 20 delay cycles + 2 for FETCH/DECODE
    set_tbl(0, 16'hF002, 16'h1105, 16'hFF00, 16'h0000);
    set_tbl(1, 16'hFF00, 16'h0000, 16'h0000, 16'h0000);
    b = n_ms;
    pulse_start(1'b0);
    wait_end("t2");
    chk("t2_nxact", n_ms - b, 32'd1);
    chk("t2_lat",   ms_cyc[b] - s_cyc, 32'd25);
    chk("t2_done",  32'(done), 32'd1);

    // 0 ms delay behaves as 1 ms
    set_tbl(0, 16'hF000, 16'h1105, 16'hFF00, 16'h0000);
    b = n_ms;
    pulse_start(1'b0);
    wait_end("t2b");
    chk("t2b_lat", ms_cyc[b] - s_cyc, 32'd15);

    // Verify on: first read corrupted, reg 12 never read back
    set_tbl(0, 16'h1380, 16'h1400, 16'hFF00, 16'h0000);
    set_tbl(1, 16'h1255, 16'hFF00, 16'h0000, 16'h0000);
    corrupt_at = n_rd;
    b  = n_ms;
    w0 = n_wr;
    r0 = n_rd;
    pulse_start(1'b1);
    wait_end("t3");
    corrupt_at = 32'hFFFF_FFFF;
    chk("t3_writes", n_wr - w0, 32'd4);
    chk("t3_reads",  n_rd - r0, 32'd3);
    chk("t3_rd1",    32'(ms_rdv[b+1]),  32'd1);
    chk("t3_rdaddr", 32'(ms_addr[b+1]), 32'h43);
    chk("t3_rewr",   32'(ms_sub[b+2]),  32'h13);
    chk("t3_rewr_rd", 32'(ms_rdv[b+2]), 32'd0);
    chk("t3_cam1",   32'(ms_cam[b+6]),  32'd1);
    chk("t3_done",   32'(done),  32'd1);
    chk("t3_error",  32'(error), 32'd0);

    // Entry 3 of camera 1 always NACKs: 1 + 3 retries then abort
    set_tbl(0, 16'h1001, 16'hFF00, 16'h0000, 16'h0000);
    set_tbl(1, 16'h2001, 16'h2102, 16'h2203, 16'h2304);
    nack_en  = 1'b1;
    nack_cam = 2'd1;
    nack_sub = 8'h23;
    b = n_ms;
    pulse_start(1'b0);
    wait_end("t4");
    nack_en = 1'b0;
    cnt = 0;
    for (int unsigned i = b; i < n_ms && i < 128; i++)
      if (ms_sub[i] == 8'h23) cnt++;
    chk("t4_nxact",   n_ms - b, 32'd8);
    chk("t4_attempt", cnt, 32'd4);
    chk("t4_error",   32'(error),   32'd1);
    chk("t4_done",    32'(done),    32'd0);
    chk("t4_errcam",  32'(err_cam), 32'd1);
    chk("t4_erridx",  32'(err_idx), 32'd3);
    chk("t4_busy",    32'(busy),    32'd0);

    // Reset while waiting on the second write of camera 0
    set_tbl(0, 16'h1280, 16'h1100, 16'hFF00, 16'h0000);
    set_tbl(1, 16'h1280, 16'h1100, 16'hFF00, 16'h0000);
    b = n_ms;
    pulse_start(1'b0);
    chk("t5_err_clr", 32'(error), 32'd0);
    cnt = 0;
    while (n_ms - b < 2 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5_wait_timeout", 32'(cnt >= 200), 32'd0);
    chk("t5_pre_tbl",   32'(tbl_addr), 32'd1);
    chk("t5_pre_maddr", 32'(m_addr),   32'h42);
    reset = 1'b1;
    #1;
    chk("t5_busy",  32'(busy),      32'd0);
    chk("t5_tbl",   32'(tbl_addr),  32'd0);
    chk("t5_cam",   32'(cam_sel),   32'd0);
    chk("t5_maddr", 32'(m_addr),    32'd0);
    chk("t5_msub",  32'(m_subaddr), 32'd0);
    chk("t5_done",  32'(done),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    b = n_ms;
    pulse_start(1'b0);
    wait_end("t5");
    chk("t5_nxact", n_ms - b, 32'd4);
    chk("t5_first_tbl", 32'(ms_tbl[b]), 32'd0);
    chk("t5_first_cam", 32'(ms_cam[b]), 32'd0);
    chk("t5_first_sub", 32'(ms_sub[b]), 32'h12);
    chk("t5_done2", 32'(done), 32'd1);

    // Full tables without end marker: implicit end at TBL_DEPTH-1
    set_tbl(0, 16'h3001, 16'h3102, 16'h3203, 16'h3304);
    set_tbl(1, 16'h4001, 16'h4102, 16'h4203, 16'h4304);
    b = n_ms;
    pulse_start(1'b0);
    chk("t6_done_clr", 32'(done), 32'd0);
    wait_end("t6");
    chk("t6_nxact", n_ms - b, 32'd8);
    chk("t6_cam3",  32'(ms_cam[b+3]), 32'd0);
    chk("t6_cam4",  32'(ms_cam[b+4]), 32'd1);
    chk("t6_last",  32'(ms_sub[b+7]), 32'h43);
    chk("t6_done",  32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_init_seq.md
SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

Interface
REQ-001 SHALL have parameter NUM_CAM, default 2: number of cameras initialised in sequence (1..4).
REQ-002 SHALL have parameter TBL_DEPTH, default 64: number of init-table entries per camera (2..256).
REQ-003 SHALL have parameter CHIP_ADDR, default 8'h42: 8-bit SCCB write address; bit 0 is forced 0 for writes and 1 for reads.
REQ-004 SHALL have parameter CYC_PER_MS, default 50000: clk cycles per millisecond for delay entries.
REQ-005 SHALL have parameter MAX_RETRY, default 3: extra attempts allowed per entry on NACK or verify mismatch.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, declared as follows.
- clk  in  1  system clock
- reset  in  1  async active-high reset
REQ-007 SHALL have the following control ports.
- start  in  1  pulse; begin the full sequence
- verify_en  in  1  sampled at start; read back each write and compare
- busy  out  1  sequence in progress
- done  out  1  level; sequence finished without error
- error  out  1  level; sequence aborted
- err_cam  out  2  camera index at abort
- err_idx  out  8  entry index at abort
REQ-008 SHALL have the following table and SCCB-master ports.
- cam_sel  out  2  camera currently addressed; also selects the SCCB mux
- tbl_addr  out  8  table entry index
- tbl_data  in  16  {sub_addr, value}; valid 1 cycle after tbl_addr
- m_start  out  1  1-cycle request to the SCCB master
- m_rd  out  1  1 = read transaction
- m_addr  out  8  chip address
- m_subaddr  out  8  register address
- m_wdata  out  8  write data
- m_rdata  in  8  read data, valid with m_done
- m_done  in  1  1-cycle pulse; transaction complete
- m_nack  in  1  valid with m_done; slave NACK

Function
REQ-009 SHALL implement states IDLE, FETCH, DECODE, WRITE, WAIT_W, READ, WAIT_R, DELAY, NEXT, FINISH, ABORT.
REQ-010 SHALL, in IDLE, take start to FETCH with cam_sel=0, tbl_addr=0 and retry=0, and SHALL latch verify_en at that edge.
REQ-011 SHALL, in FETCH, wait one cycle for ROM latency and then go to DECODE.
REQ-012 SHALL decode sub_addr 8'hFF as end-of-table (go to NEXT), 8'hF0 as a delay of value ms (go to DELAY; value 0 means 1 ms), and any other value as a register write (go to WRITE).
REQ-013 SHALL, in WRITE, pulse m_start for exactly one cycle with m_rd=0 and m_addr=CHIP_ADDR&8'hFE, then wait in WAIT_W for m_done.
REQ-014 SHALL, in WAIT_W on m_done: if m_nack, retry the entry; else, if verify is latched and sub_addr!=8'h12, go to READ; otherwise advance.
REQ-015 SHALL, in READ, issue a read transaction with m_addr=CHIP_ADDR|8'h01, then wait in WAIT_R; on m_done, a NACK or m_rdata!=value SHALL retry the entry, and a match SHALL advance.
REQ-016 SHALL implement retry as: retry<MAX_RETRY -> retry+1 and return to WRITE; otherwise go to ABORT with err_cam/err_idx latched.
REQ-017 SHALL implement advance as: retry=0, tbl_addr+1, go to FETCH; tbl_addr==TBL_DEPTH-1 SHALL instead go to NEXT (implicit end).
REQ-018 SHALL, in NEXT, go to FINISH if cam_sel==NUM_CAM-1; otherwise set cam_sel+1, tbl_addr=0 and go to FETCH.
REQ-019 SHALL, in DELAY, count value×CYC_PER_MS cycles using a 32-bit counter with no overflow, then advance.
REQ-020 SHALL hold done=1 in FINISH and error=1 in ABORT until the next start, which clears both and restarts from camera 0.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL drive busy=1 in every state except IDLE, FINISH and ABORT.
REQ-023 SHALL treat an m_done arriving outside WAIT_W/WAIT_R as ignored.

Reset
REQ-024 SHALL, on reset assertion, set state=IDLE and all outputs to 0 immediately, including m_start, cam_sel, tbl_addr, err_*, done and error.
REQ-025 SHALL, if reset occurs mid-sequence, abandon the sequence; the next start re-runs it from entry 0 of camera 0.

Structure
REQ-026 SHALL place the state enum, the 8'hF0/8'hFF opcode constants and the table-entry struct in package sccb_init_pkg.
REQ-027 SHALL implement the millisecond delay as sub-module init_delay_timer (load, ms count, expired pulse).
REQ-028 SHALL NOT contain any SCCB bit-level timing; the table ROM is external.

Verification
REQ-029 Bench SHALL cover: NUM_CAM=2, table {12/80, 11/00, FF/xx}, model ACKs all -> 4 writes, cam_sel 0 then 1, done=1, error=0.
REQ-030 Bench SHALL cover: entry F0/02 with CYC_PER_MS=10 -> next m_start exactly 20 cycles (±FETCH/DECODE overhead, fixed) after DELAY entry.
REQ-031 Bench SHALL cover: verify_en=1, model returns m_rdata=value^1 on first read only -> one rewrite, then match, done=1.
REQ-032 Bench SHALL cover: model NACKs entry 3 of cam 1 always, MAX_RETRY=3 -> 4 attempts, error=1, err_cam=1, err_idx=3.
REQ-033 Bench SHALL cover: reset asserted in WAIT_W -> outputs 0 same cycle; new start runs from tbl_addr=0, cam_sel=0.
REQ-034 Bench SHALL cover: table without FF, TBL_DEPTH=4 -> exactly 4 writes per camera, then done.
